// File: rtl/axi4_remap_pkg.sv
// Shared definitions for the AXI4 ID remapper: default widths and counter sizing.
package axi4_remap_pkg;

  localparam int DEF_IN_ID_W  = 7;
  localparam int DEF_OUT_ID_W = 2;
  localparam int DEF_MAX_OUT  = 8;
  localparam int DEF_PAY_W    = 64;

  // The counter must be able to hold MAX_OUT itself, not just MAX_OUT-1.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/axi4_id_remapper_if.sv
// Request/response bus bundle around the remapper: upstream (in_*) and downstream (out_*) sides.
interface axi4_id_remapper_if #(
  parameter int IN_ID_W  = 7,
  parameter int OUT_ID_W = 2,
  parameter int AR_PAY_W = 64,
  parameter int AW_PAY_W = 64
);
  logic                in_ar_valid, in_ar_ready;
  logic [IN_ID_W-1:0]  in_ar_id;
  logic [AR_PAY_W-1:0] in_ar_payload;
  logic                out_ar_valid, out_ar_ready;
  logic [OUT_ID_W-1:0] out_ar_id;
  logic [AR_PAY_W-1:0] out_ar_payload;

  logic                in_aw_valid, in_aw_ready;
  logic [IN_ID_W-1:0]  in_aw_id;
  logic [AW_PAY_W-1:0] in_aw_payload;
  logic                out_aw_valid, out_aw_ready;
  logic [OUT_ID_W-1:0] out_aw_id;
  logic [AW_PAY_W-1:0] out_aw_payload;

  logic                out_r_valid, out_r_ready, out_r_last;
  logic [OUT_ID_W-1:0] out_r_id;
  logic                in_r_valid, in_r_ready;
  logic [IN_ID_W-1:0]  in_r_id;

  logic                out_b_valid, out_b_ready;
  logic [OUT_ID_W-1:0] out_b_id;
  logic                in_b_valid, in_b_ready;
  logic [IN_ID_W-1:0]  in_b_id;

  // master: the surrounding system (bridge above, slave below); slave: the remapper.
  modport master (
    output in_ar_valid, in_ar_id, in_ar_payload, out_ar_ready,
    output in_aw_valid, in_aw_id, in_aw_payload, out_aw_ready,
    output out_r_valid, out_r_id, out_r_last, in_r_ready,
    output out_b_valid, out_b_id, in_b_ready,
    input  in_ar_ready, out_ar_valid, out_ar_id, out_ar_payload,
    input  in_aw_ready, out_aw_valid, out_aw_id, out_aw_payload,
    input  out_r_ready, in_r_valid, in_r_id,
    input  out_b_ready, in_b_valid, in_b_id
  );

  modport slave (
    input  in_ar_valid, in_ar_id, in_ar_payload, out_ar_ready,
    input  in_aw_valid, in_aw_id, in_aw_payload, out_aw_ready,
    input  out_r_valid, out_r_id, out_r_last, in_r_ready,
    input  out_b_valid, out_b_id, in_b_ready,
    output in_ar_ready, out_ar_valid, out_ar_id, out_ar_payload,
    output in_aw_ready, out_aw_valid, out_aw_id, out_aw_payload,
    output out_r_ready, in_r_valid, in_r_id,
    output out_b_ready, in_b_valid, in_b_id
  );
endinterface

// File: rtl/axi4_id_remap_table.sv
// One direction's remap table: NSLOT entries of {valid, upstream id, outstanding count}.
module axi4_id_remap_table
  import axi4_remap_pkg::*;
#(
  parameter int IN_ID_W  = DEF_IN_ID_W,
  parameter int OUT_ID_W = DEF_OUT_ID_W,
  parameter int MAX_OUT  = DEF_MAX_OUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_ID_W-1:0]  req_id_i,
  input  logic                req_fire_i,
  output logic [OUT_ID_W-1:0] sel_slot_o,
  output logic                can_issue_o,
  input  logic [OUT_ID_W-1:0] rsp_slot_i,
  input  logic                rsp_fire_i,
  input  logic                rsp_retire_i,
  output logic [IN_ID_W-1:0]  rsp_in_id_o,
  output logic                bad_o,
  output logic                busy_o
);
  localparam int NSLOT = 1 << OUT_ID_W;
  localparam int CW    = cnt_w(MAX_OUT);

  typedef struct packed {
    logic               valid;
    logic [IN_ID_W-1:0] in_id;
    logic [CW-1:0]      count;
  } entry_t;

  entry_t              tbl_q [NSLOT];
  entry_t              tbl_d [NSLOT];
  logic                hit, free_ok;
  logic [OUT_ID_W-1:0] hit_slot, free_slot;
  logic [NSLOT-1:0]    inc, dec, valid_vec;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit       = 1'b0;
    hit_slot  = '0;
    free_ok   = 1'b0;
    free_slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && (tbl_q[i].in_id == req_id_i)) begin
        hit      = 1'b1;
        hit_slot = OUT_ID_W'(i);
      end
      if (!tbl_q[i].valid) begin
        free_ok   = 1'b1;
        free_slot = OUT_ID_W'(i);
      end
    end
    sel_slot_o  = hit ? hit_slot : free_slot;
    can_issue_o = hit ? (tbl_q[hit_slot].count < CW'(MAX_OUT)) : free_ok;
  end

  always_comb begin
    inc       = '0;
    dec       = '0;
    valid_vec = '0;
    for (int i = 0; i < NSLOT; i++) begin
      tbl_d[i]     = tbl_q[i];
      valid_vec[i] = tbl_q[i].valid;
      inc[i]       = req_fire_i && (sel_slot_o == OUT_ID_W'(i));
      dec[i]       = rsp_retire_i && (rsp_slot_i == OUT_ID_W'(i)) && tbl_q[i].valid;
      if (inc[i] && !dec[i])
        tbl_d[i].count = tbl_q[i].count + CW'(1);
      else if (dec[i] && !inc[i])
        tbl_d[i].count = tbl_q[i].count - CW'(1);
      if (inc[i])
        tbl_d[i].in_id = req_id_i;
      tbl_d[i].valid = (tbl_d[i].count != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  // A stale slot still returns its last stored id; the caller flags it via bad_o.
  assign rsp_in_id_o = tbl_q[rsp_slot_i].in_id;
  assign bad_o       = rsp_fire_i && !tbl_q[rsp_slot_i].valid;
  assign busy_o      = |valid_vec;

endmodule

// File: rtl/axi4_id_remapper.sv
// Compresses wide upstream AXI4 IDs onto a small downstream ID pool and restores them on R/B.
module axi4_id_remapper
  import axi4_remap_pkg::*;
#(
  parameter int IN_ID_W  = DEF_IN_ID_W,
  parameter int OUT_ID_W = DEF_OUT_ID_W,
  parameter int MAX_OUT  = DEF_MAX_OUT,
  parameter int AR_PAY_W = DEF_PAY_W,
  parameter int AW_PAY_W = DEF_PAY_W
) (
  input  logic                  clock,
  input  logic                  reset,
  axi4_id_remapper_if.slave     bus,
  output logic                  rd_busy,
  output logic                  wr_busy,
  output logic                  err_bad_resp
);
  logic                rd_can, wr_can, rd_bad, wr_bad, err_q, err_d;
  logic [OUT_ID_W-1:0] rd_sel, wr_sel;
  logic [IN_ID_W-1:0]  rd_rsp_id, wr_rsp_id;

  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_rd_tbl (
    .clk         (clock),
    .rst         (reset),
    .req_id_i    (bus.in_ar_id),
    .req_fire_i  (bus.in_ar_valid && bus.in_ar_ready),
    .sel_slot_o  (rd_sel),
    .can_issue_o (rd_can),
    .rsp_slot_i  (bus.out_r_id),
    .rsp_fire_i  (bus.out_r_valid && bus.in_r_ready),
    .rsp_retire_i(bus.out_r_valid && bus.in_r_ready && bus.out_r_last),
    .rsp_in_id_o (rd_rsp_id),
    .bad_o       (rd_bad),
    .busy_o      (rd_busy)
  );

  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_wr_tbl (
    .clk         (clock),
    .rst         (reset),
    .req_id_i    (bus.in_aw_id),
    .req_fire_i  (bus.in_aw_valid && bus.in_aw_ready),
    .sel_slot_o  (wr_sel),
    .can_issue_o (wr_can),
    .rsp_slot_i  (bus.out_b_id),
    .rsp_fire_i  (bus.out_b_valid && bus.in_b_ready),
    .rsp_retire_i(bus.out_b_valid && bus.in_b_ready),
    .rsp_in_id_o (wr_rsp_id),
    .bad_o       (wr_bad),
    .busy_o      (wr_busy)
  );

  // out_*_valid must not look at out_*_ready, so only can_issue gates it.
  assign bus.out_ar_valid   = bus.in_ar_valid && rd_can;
  assign bus.in_ar_ready    = bus.out_ar_ready && rd_can;
  assign bus.out_ar_id      = rd_sel;
  assign bus.out_ar_payload = bus.in_ar_payload;

  assign bus.out_aw_valid   = bus.in_aw_valid && wr_can;
  assign bus.in_aw_ready    = bus.out_aw_ready && wr_can;
  assign bus.out_aw_id      = wr_sel;
  assign bus.out_aw_payload = bus.in_aw_payload;

  assign bus.in_r_valid  = bus.out_r_valid;
  assign bus.out_r_ready = bus.in_r_ready;
  assign bus.in_r_id     = rd_rsp_id;

  assign bus.in_b_valid  = bus.out_b_valid;
  assign bus.out_b_ready = bus.in_b_ready;
  assign bus.in_b_id     = wr_rsp_id;

  assign err_d = err_q || rd_bad || wr_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_bad_resp = err_q;

endmodule

// File: tb/tb_axi4_id_remapper.sv
// Directed bench for axi4_id_remapper: allocation, credit limits, retire timing, error flag, reset.
module tb_axi4_id_remapper;
  localparam int IN_ID_W  = 7;
  localparam int OUT_ID_W = 2;
  localparam int MAX_OUT  = 4;
  localparam int AR_PAY_W = 64;
  localparam int AW_PAY_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_busy, wr_busy, err_bad_resp;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  axi4_id_remapper_if #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W),
                        .AR_PAY_W(AR_PAY_W), .AW_PAY_W(AW_PAY_W)) bus ();

  axi4_id_remapper #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT),
                     .AR_PAY_W(AR_PAY_W), .AW_PAY_W(AW_PAY_W)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus.slave),
    .rd_busy     (rd_busy),
    .wr_busy     (wr_busy),
    .err_bad_resp(err_bad_resp)
  );

  task automatic idle();
    bus.in_ar_valid = 1'b0; bus.in_ar_id = '0; bus.in_ar_payload = '0; bus.out_ar_ready = 1'b1;
    bus.in_aw_valid = 1'b0; bus.in_aw_id = '0; bus.in_aw_payload = '0; bus.out_aw_ready = 1'b1;
    bus.out_r_valid = 1'b0; bus.out_r_id = '0; bus.out_r_last = 1'b0; bus.in_r_ready = 1'b1;
    bus.out_b_valid = 1'b0; bus.out_b_id = '0; bus.in_b_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h33; bus.out_ar_ready = 1'b0;
    #1;
    checks++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL reset_rd_busy: got %0b expected 0", rd_busy); end
    checks++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL reset_wr_busy: got %0b expected 0", wr_busy); end
    checks++; if (err_bad_resp !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b expected 0", err_bad_resp); end
    checks++; if (bus.out_ar_id !== 2'd0) begin fails++; $display("FAIL reset_first_slot: got %0d expected 0", bus.out_ar_id); end
    checks++; if (bus.out_ar_valid !== 1'b1) begin fails++; $display("FAIL reset_valid_no_ready: got %0b expected 1", bus.out_ar_valid); end
    checks++; if (bus.in_ar_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_follows: got %0b expected 0", bus.in_ar_ready); end
  endtask

  task automatic test_basic_alloc();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h45; bus.in_ar_payload = 64'hDEAD_BEEF_0123_4567;
    #1;
    checks++; if (bus.out_ar_id !== 2'd0) begin fails++; $display("FAIL basic_id45_slot: got %0d expected 0", bus.out_ar_id); end
    checks++; if (bus.in_ar_ready !== 1'b1) begin fails++; $display("FAIL basic_id45_ready: got %0b expected 1", bus.in_ar_ready); end
    checks++; if (bus.out_ar_payload !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL basic_payload: got %0h expected deadbeef01234567", bus.out_ar_payload); end
    @(negedge clk);
    bus.in_ar_id = 7'h12;
    #1;
    checks++; if (bus.out_ar_id !== 2'd1) begin fails++; $display("FAIL basic_id12_slot: got %0d expected 1", bus.out_ar_id); end
    checks++; if (rd_busy !== 1'b1) begin fails++; $display("FAIL basic_rd_busy: got %0b expected 1", rd_busy); end
    @(negedge clk);
    bus.in_ar_id = 7'h77; bus.out_ar_ready = 1'b0;
    bus.out_r_valid = 1'b1; bus.out_r_id = 2'd1; bus.out_r_last = 1'b1;
    #1;
    checks++; if (bus.in_r_id !== 7'h12) begin fails++; $display("FAIL basic_r_restore: got %0h expected 12", bus.in_r_id); end
    checks++; if (bus.in_r_valid !== 1'b1) begin fails++; $display("FAIL basic_r_valid: got %0b expected 1", bus.in_r_valid); end
    checks++; if (bus.out_ar_id !== 2'd2) begin fails++; $display("FAIL basic_no_same_cycle_free: got %0d expected 2", bus.out_ar_id); end
    @(negedge clk);
    bus.out_r_valid = 1'b0;
    #1;
    checks++; if (bus.out_ar_id !== 2'd1) begin fails++; $display("FAIL basic_slot1_freed: got %0d expected 1", bus.out_ar_id); end
    bus.in_ar_valid = 1'b0;
  endtask

  task automatic test_max_out();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h45;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.out_ar_id !== 2'd0 || bus.in_ar_ready !== 1'b1) begin
        fails++; $display("FAIL maxout_fill%0d: got slot %0d ready %0b expected slot 0 ready 1", k, bus.out_ar_id, bus.in_ar_ready);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.in_ar_ready !== 1'b0) begin fails++; $display("FAIL maxout_stall_ready: got %0b expected 0", bus.in_ar_ready); end
    checks++; if (bus.out_ar_valid !== 1'b0) begin fails++; $display("FAIL maxout_stall_valid: got %0b expected 0", bus.out_ar_valid); end
    bus.out_r_valid = 1'b1; bus.out_r_id = 2'd0; bus.out_r_last = 1'b1;
    #1;
    checks++; if (bus.in_ar_ready !== 1'b0) begin fails++; $display("FAIL maxout_credit_not_same_cycle: got %0b expected 0", bus.in_ar_ready); end
    @(negedge clk);
    bus.out_r_valid = 1'b0; bus.out_ar_ready = 1'b0;
    #1;
    checks++; if (bus.out_ar_valid !== 1'b1) begin fails++; $display("FAIL maxout_valid_indep_ready: got %0b expected 1", bus.out_ar_valid); end
    bus.out_ar_ready = 1'b1;
    #1;
    checks++; if (bus.in_ar_ready !== 1'b1 || bus.out_ar_id !== 2'd0) begin
      fails++; $display("FAIL maxout_fifth_issue: got ready %0b slot %0d expected ready 1 slot 0", bus.in_ar_ready, bus.out_ar_id);
    end
    @(negedge clk);
    bus.in_ar_id = 7'h46;
    #1;
    checks++; if (bus.out_ar_id !== 2'd1 || bus.in_ar_ready !== 1'b1) begin
      fails++; $display("FAIL maxout_other_id: got slot %0d ready %0b expected slot 1 ready 1", bus.out_ar_id, bus.in_ar_ready);
    end
    bus.in_ar_valid = 1'b0;
  endtask

  task automatic test_slot_full();
    logic [IN_ID_W-1:0] ids [4];
    ids[0] = 7'h10; ids[1] = 7'h20; ids[2] = 7'h30; ids[3] = 7'h40;
    apply_reset();
    bus.in_aw_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_aw_id = ids[k];
      #1;
      checks++; if (bus.out_aw_id !== OUT_ID_W'(k)) begin fails++; $display("FAIL full_alloc%0d: got %0d expected %0d", k, bus.out_aw_id, k); end
      @(negedge clk);
    end
    bus.in_aw_id = 7'h50;
    #1;
    checks++; if (bus.in_aw_ready !== 1'b0 || bus.out_aw_valid !== 1'b0) begin
      fails++; $display("FAIL full_stall: got ready %0b valid %0b expected 0 0", bus.in_aw_ready, bus.out_aw_valid);
    end
    bus.out_b_valid = 1'b1; bus.out_b_id = 2'd2;
    #1;
    checks++; if (bus.in_b_id !== 7'h30) begin fails++; $display("FAIL full_b_restore: got %0h expected 30", bus.in_b_id); end
    checks++; if (bus.in_aw_ready !== 1'b0) begin fails++; $display("FAIL full_same_cycle: got %0b expected 0", bus.in_aw_ready); end
    @(negedge clk);
    bus.out_b_valid = 1'b0;
    #1;
    checks++; if (bus.in_aw_ready !== 1'b1 || bus.out_aw_id !== 2'd2) begin
      fails++; $display("FAIL full_next_cycle_alloc: got ready %0b slot %0d expected 1 2", bus.in_aw_ready, bus.out_aw_id);
    end
    @(negedge clk);
    bus.in_aw_valid = 1'b0;
    #1;
    checks++; if (wr_busy !== 1'b1 || rd_busy !== 1'b0) begin
      fails++; $display("FAIL full_busy: got wr %0b rd %0b expected 1 0", wr_busy, rd_busy);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h45;
    @(negedge clk);
    bus.out_r_valid = 1'b1; bus.out_r_id = 2'd0; bus.out_r_last = 1'b1;
    #1;
    checks++; if (bus.out_ar_id !== 2'd0 || bus.in_ar_ready !== 1'b1) begin
      fails++; $display("FAIL same_issue: got slot %0d ready %0b expected 0 1", bus.out_ar_id, bus.in_ar_ready);
    end
    checks++; if (bus.in_r_id !== 7'h45) begin fails++; $display("FAIL same_r_id: got %0h expected 45", bus.in_r_id); end
    @(negedge clk);
    bus.in_ar_valid = 1'b0; bus.out_r_valid = 1'b0;
    #1;
    checks++; if (rd_busy !== 1'b1) begin fails++; $display("FAIL same_valid_kept: got %0b expected 1", rd_busy); end
    bus.out_r_valid = 1'b1;
    @(negedge clk);
    bus.out_r_valid = 1'b0;
    #1;
    checks++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL same_count_was_one: got %0b expected 0", rd_busy); end
    checks++; if (err_bad_resp !== 1'b0) begin fails++; $display("FAIL same_no_err: got %0b expected 0", err_bad_resp); end
  endtask

  task automatic test_burst();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h11;
    bus.in_aw_valid = 1'b1; bus.in_aw_id = 7'h22;
    @(negedge clk);
    bus.in_aw_valid = 1'b0; bus.in_ar_id = 7'h22;
    #1;
    checks++; if (bus.out_ar_id !== 2'd1) begin fails++; $display("FAIL burst_alloc: got %0d expected 1", bus.out_ar_id); end
    @(negedge clk);
    bus.in_ar_id = 7'h66; bus.out_ar_ready = 1'b0;
    bus.out_r_valid = 1'b1; bus.out_r_id = 2'd1; bus.out_r_last = 1'b0;
    bus.out_b_valid = 1'b1; bus.out_b_id = 2'd0;
    #1;
    checks++; if (bus.in_r_id !== 7'h22) begin fails++; $display("FAIL burst_beat0_id: got %0h expected 22", bus.in_r_id); end
    checks++; if (bus.in_b_id !== 7'h22) begin fails++; $display("FAIL burst_b_id: got %0h expected 22", bus.in_b_id); end
    @(negedge clk);
    bus.out_b_valid = 1'b0;
    #1;
    checks++; if (bus.out_ar_id !== 2'd2) begin fails++; $display("FAIL burst_nonlast_keeps: got %0d expected 2", bus.out_ar_id); end
    checks++; if (wr_busy !== 1'b0 || rd_busy !== 1'b1) begin
      fails++; $display("FAIL burst_b_isolated: got wr %0b rd %0b expected 0 1", wr_busy, rd_busy);
    end
    @(negedge clk);
    bus.out_r_last = 1'b1;
    #1;
    checks++; if (bus.out_ar_id !== 2'd2) begin fails++; $display("FAIL burst_second_nonlast: got %0d expected 2", bus.out_ar_id); end
    @(negedge clk);
    bus.out_r_valid = 1'b0;
    #1;
    checks++; if (bus.out_ar_id !== 2'd1) begin fails++; $display("FAIL burst_last_frees: got %0d expected 1", bus.out_ar_id); end
    bus.in_ar_id = 7'h11;
    #1;
    checks++; if (bus.out_ar_id !== 2'd0 || bus.in_ar_ready !== 1'b0 || bus.out_ar_valid !== 1'b1) begin
      fails++; $display("FAIL burst_read_untouched: got slot %0d valid %0b expected slot 0 valid 1", bus.out_ar_id, bus.out_ar_valid);
    end
    bus.in_ar_valid = 1'b0;
  endtask

  task automatic test_bad_resp();
    apply_reset();
    bus.out_b_valid = 1'b1; bus.out_b_id = 2'd3;
    #1;
    checks++; if (bus.in_b_id !== 7'h00 || bus.in_b_valid !== 1'b1) begin
      fails++; $display("FAIL bad_forward: got id %0h valid %0b expected 0 1", bus.in_b_id, bus.in_b_valid);
    end
    checks++; if (err_bad_resp !== 1'b0) begin fails++; $display("FAIL bad_registered: got %0b expected 0", err_bad_resp); end
    @(negedge clk);
    bus.out_b_valid = 1'b0;
    #1;
    checks++; if (err_bad_resp !== 1'b1 || wr_busy !== 1'b0) begin
      fails++; $display("FAIL bad_set: got err %0b wr_busy %0b expected 1 0", err_bad_resp, wr_busy);
    end
    @(negedge clk);
    #1;
    checks++; if (err_bad_resp !== 1'b1) begin fails++; $display("FAIL bad_sticky: got %0b expected 1", err_bad_resp); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.in_ar_valid = 1'b1; bus.in_ar_id = 7'h45;
    @(negedge clk);
    bus.in_ar_id = 7'h12;
    @(negedge clk);
    bus.out_ar_ready = 1'b0;
    bus.out_r_valid = 1'b1; bus.out_r_id = 2'd1; bus.out_r_last = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.in_r_id !== 7'h12 || rd_busy !== 1'b1) begin
      fails++; $display("FAIL arst_before: got id %0h busy %0b expected 12 1", bus.in_r_id, rd_busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.in_r_id !== 7'h00) begin fails++; $display("FAIL arst_table_clear: got %0h expected 0", bus.in_r_id); end
    checks++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %0b expected 0", rd_busy); end
    checks++; if (bus.out_ar_id !== 2'd0) begin fails++; $display("FAIL arst_ar_slot: got %0d expected 0", bus.out_ar_id); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (err_bad_resp !== 1'b0) begin fails++; $display("FAIL arst_err_clear: got %0b expected 0", err_bad_resp); end
    @(negedge clk);
    bus.out_r_valid = 1'b0; bus.in_ar_valid = 1'b0;
    #1;
    checks++; if (err_bad_resp !== 1'b1) begin fails++; $display("FAIL arst_inflight_err: got %0b expected 1", err_bad_resp); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_alloc();
    test_max_out();
    test_slot_full();
    test_same_cycle();
    test_burst();
    test_bad_resp();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
